// File: rtl/add_seq_16.sv
// Slice-serial adder: WIDTH-bit A+B+C_in computed SLICE bits per cycle, valid/ready on both sides.
// Optional signed-overflow output OVF_out is built only when ADD_SEQ_OVF_EN is defined.
module add_seq_16 #(
   parameter int WIDTH = 16,
   parameter int SLICE = 4
) (
   input  logic             CLK_in,
   input  logic             RSTn_in,
   input  logic [WIDTH-1:0] A_in,
   input  logic [WIDTH-1:0] B_in,
   input  logic             C_in,
   input  logic             VALID_in,
   output logic             READY_out,
   output logic [WIDTH-1:0] S_out,
   output logic             C_out,
   output logic             VALID_out,
   input  logic             READY_in
`ifdef ADD_SEQ_OVF_EN
   ,output logic            OVF_out
`endif
);

   localparam int N  = WIDTH / SLICE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;
   localparam logic [KW-1:0] K_LAST = KW'(N - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
   logic [KW-1:0]    k_q, k_d;
   logic             cy_q, cy_d, co_q, co_d;
`ifdef ADD_SEQ_OVF_EN
   logic             ovf_q, ovf_d;
`endif

   logic [SLICE-1:0] a_sl, b_sl;
   logic [SLICE:0]   sum_sl;

   // One slice per cycle; cy_q carries the ripple between slices (seeded with C_in).
   assign a_sl   = a_q[k_q*SLICE +: SLICE];
   assign b_sl   = b_q[k_q*SLICE +: SLICE];
   assign sum_sl = {1'b0, a_sl} + {1'b0, b_sl} + {{SLICE{1'b0}}, cy_q};

   always_ff @(posedge CLK_in or negedge RSTn_in) begin
      if (!RSTn_in) state_q <= IDLE;
      else          state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (VALID_in)        state_d = RUN;
         RUN:     if (k_q == K_LAST)   state_d = DONE;
         DONE:    if (READY_in)        state_d = IDLE;
         default:                      state_d = IDLE;
      endcase
   end

   always_comb begin
      READY_out = (state_q == IDLE);
      VALID_out = (state_q == DONE);
   end

   always_comb begin
      a_d  = a_q;
      b_d  = b_q;
      cy_d = cy_q;
      k_d  = k_q;
      s_d  = s_q;
      co_d = co_q;
`ifdef ADD_SEQ_OVF_EN
      ovf_d = ovf_q;
`endif
      case (state_q)
         IDLE: begin
            if (VALID_in) begin
               a_d  = A_in;
               b_d  = B_in;
               cy_d = C_in;
               k_d  = '0;
            end
         end
         RUN: begin
            s_d[k_q*SLICE +: SLICE] = sum_sl[SLICE-1:0];
            cy_d = sum_sl[SLICE];
            k_d  = k_q + 1'b1;
            if (k_q == K_LAST) begin
               co_d = sum_sl[SLICE];
               k_d  = '0;
`ifdef ADD_SEQ_OVF_EN
               ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_sl[SLICE-1] != a_q[WIDTH-1]);
`endif
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_in or negedge RSTn_in) begin
      if (!RSTn_in) begin
         a_q  <= '0;
         b_q  <= '0;
         cy_q <= 1'b0;
         k_q  <= '0;
         s_q  <= '0;
         co_q <= 1'b0;
`ifdef ADD_SEQ_OVF_EN
         ovf_q <= 1'b0;
`endif
      end else begin
         a_q  <= a_d;
         b_q  <= b_d;
         cy_q <= cy_d;
         k_q  <= k_d;
         s_q  <= s_d;
         co_q <= co_d;
`ifdef ADD_SEQ_OVF_EN
         ovf_q <= ovf_d;
`endif
      end
   end

   assign S_out = s_q;
   assign C_out = co_q;
`ifdef ADD_SEQ_OVF_EN
   assign OVF_out = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_16.sv
// Directed bench for add_seq_16: hand-computed sums, latency, stall, mid-run reset.
// Define ADD_SEQ_OVF_EN to also check OVF_out.
module tb_add_seq_16;
   localparam int W = 16;
   localparam int N = 4;

   logic         CLK_in = 1'b0;
   logic         RSTn_in = 1'b0;
   logic [W-1:0] A_in = '0, B_in = '0;
   logic         C_in = 1'b0, VALID_in = 1'b0, READY_in = 1'b0;
   logic         READY_out, C_out, VALID_out;
   logic [W-1:0] S_out;
`ifdef ADD_SEQ_OVF_EN
   logic         OVF_out;
`endif

   int n_vec = 0;
   int n_err = 0;

   add_seq_16 #(.WIDTH(W), .SLICE(4)) dut (
      .CLK_in(CLK_in), .RSTn_in(RSTn_in),
      .A_in(A_in), .B_in(B_in), .C_in(C_in), .VALID_in(VALID_in),
      .READY_out(READY_out), .S_out(S_out), .C_out(C_out),
      .VALID_out(VALID_out), .READY_in(READY_in)
`ifdef ADD_SEQ_OVF_EN
      ,.OVF_out(OVF_out)
`endif
   );

   always #5 CLK_in = ~CLK_in;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accept operands, check VALID_out rises exactly N edges later, then check the result.
   task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                         input logic [W-1:0] es, input logic ec, input logic eovf);
      @(negedge CLK_in);
      chk("rdy_idle", READY_out, 1);
      A_in = a; B_in = b; C_in = c; VALID_in = 1'b1;
      @(posedge CLK_in); #1;
      VALID_in = 1'b0;
      A_in = 16'hDEAD; B_in = 16'hBEEF; C_in = 1'b1;
      chk("rdy_busy", READY_out, 0);
      for (int i = 1; i <= N; i++) begin
         @(posedge CLK_in); #1;
         chk($sformatf("lat%0d", i), VALID_out, (i == N) ? 1 : 0);
      end
      chk("sum", S_out, es);
      chk("cout", C_out, ec);
`ifdef ADD_SEQ_OVF_EN
      chk("ovf", OVF_out, eovf);
`else
      if (eovf === 1'bx) $display("unused");
`endif
   endtask

   task automatic release_res(input logic [W-1:0] es, input logic ec);
      @(negedge CLK_in);
      READY_in = 1'b1;
      @(posedge CLK_in); #1;
      READY_in = 1'b0;
      chk("idle_rdy", READY_out, 1);
      chk("idle_vld", VALID_out, 0);
      chk("hold_sum", S_out, es);
      chk("hold_co", C_out, ec);
   endtask

   initial begin
      #3;
      chk("rst_rdy", READY_out, 1);
      chk("rst_vld", VALID_out, 0);
      chk("rst_sum", S_out, 0);
      chk("rst_co", C_out, 0);
      @(negedge CLK_in); @(negedge CLK_in);
      RSTn_in = 1'b1;

      run_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0); release_res(16'h5555, 1'b0);
      run_op(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0); release_res(16'h0000, 1'b1);
      run_op(16'h0000, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0); release_res(16'h0000, 1'b1);
      run_op(16'h0F0F, 16'h00F1, 1'b0, 16'h1000, 1'b0, 1'b0); release_res(16'h1000, 1'b0);
      run_op(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1); release_res(16'h8000, 1'b0);
      run_op(16'h8000, 16'h8000, 1'b1, 16'h0001, 1'b1, 1'b1);

      // Stall in DONE with VALID_in pulsing: nothing may move.
      for (int i = 0; i < 6; i++) begin
         @(negedge CLK_in);
         VALID_in = i[0];
         A_in = 16'hAAAA; B_in = 16'h5555;
         @(posedge CLK_in); #1;
         chk("stl_sum", S_out, 16'h0001);
         chk("stl_co", C_out, 1);
         chk("stl_vld", VALID_out, 1);
         chk("stl_rdy", READY_out, 0);
      end
      @(negedge CLK_in);
      VALID_in = 1'b0;
      release_res(16'h0001, 1'b1);

      // Reset while slice k=2 is pending.
      @(negedge CLK_in);
      A_in = 16'h1111; B_in = 16'h2222; C_in = 1'b0; VALID_in = 1'b1;
      @(posedge CLK_in); #1;
      VALID_in = 1'b0;
      @(posedge CLK_in); @(posedge CLK_in); #2;
      RSTn_in = 1'b0;
      #1;
      chk("ar_rdy", READY_out, 1);
      chk("ar_vld", VALID_out, 0);
      chk("ar_sum", S_out, 0);
      chk("ar_co", C_out, 0);
`ifdef ADD_SEQ_OVF_EN
      chk("ar_ovf", OVF_out, 0);
`endif
      @(negedge CLK_in);
      RSTn_in = 1'b1;
      for (int i = 0; i < N + 2; i++) begin
         @(posedge CLK_in); #1;
         chk("ar_novld", VALID_out, 0);
      end
      run_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0); release_res(16'h0002, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1);
   end
endmodule

// File: doc/add_seq_16.md
ADD_SEQ_16 -- requirements
Module: add_seq_16

Interface
REQ-001 Parameter: WIDTH, 16, operand/result width in bits; SHALL be a multiple of SLICE.
REQ-002 Parameter: SLICE, 4, bits added per cycle; N = WIDTH/SLICE slice steps per operation.
REQ-003 Port: CLK_in  input  1  single clock; all state changes on its rising edge.
REQ-004 Port: RSTn_in  input  1  asynchronous, active-low reset.
REQ-005 Port: A_in  input  WIDTH  operand A, sampled on accept.
REQ-006 Port: B_in  input  WIDTH  operand B, sampled on accept.
REQ-007 Port: C_in  input  1  carry-in, sampled on accept.
REQ-008 Port: VALID_in  input  1  upstream operands valid.
REQ-009 Port: READY_out  output  1  block can accept operands.
REQ-010 Port: S_out  output  WIDTH  registered sum.
REQ-011 Port: C_out  output  1  registered carry-out of bit WIDTH-1.
REQ-012 Port: VALID_out  output  1  S_out/C_out hold a completed result.
REQ-013 Port: READY_in  input  1  downstream accepts result.
REQ-014 Port: OVF_out  output  1  signed overflow; present only with ADD_SEQ_OVF_EN.

Function
REQ-015 FSM states SHALL be IDLE, RUN, DONE; exactly one active.
REQ-016 IDLE: READY_out=1, VALID_out=0; VALID_in=1 at edge -> capture A_in, B_in, C_in into internal registers, clear slice index k to 0, go RUN.
REQ-017 RUN: each edge SHALL add slice k of A and B plus carry register (k=0 uses captured C_in), write SLICE sum bits to S register bits [k*SLICE+SLICE-1 : k*SLICE], store slice carry-out, increment k.
REQ-018 RUN -> DONE on the edge processing k=N-1; C_out SHALL take that slice's carry-out on the same edge.
REQ-019 Latency: VALID_out SHALL rise exactly N cycles after the accept edge (4 cycles for defaults).
REQ-020 DONE: VALID_out=1; VALID_out, S_out, C_out SHALL stay stable until READY_in=1 at an edge, then go IDLE.
REQ-021 READY_out SHALL be 1 only in IDLE; VALID_in in RUN/DONE SHALL be ignored; operand inputs may change after accept without effect.
REQ-022 Minimum accept-to-accept period SHALL be N+2 cycles (accept, N RUN edges, result handshake).
REQ-023 S_out/C_out SHALL retain the last result in IDLE until overwritten by the next RUN; arithmetic is modulo 2^WIDTH with carry in C_out.
REQ-024 Result SHALL equal A+B+C_in for all operand values, including full carry propagation across every slice boundary.

Reset
REQ-025 RSTn_in=0 SHALL immediately force IDLE, k=0, S_out=0, C_out=0, VALID_out=0, OVF_out=0, internal carry=0, READY_out=1, regardless of clock.
REQ-026 Reset during RUN or DONE SHALL discard the operation; no VALID_out pulse after release.
REQ-027 First accept possible on the first rising edge with RSTn_in=1.

Configuration
REQ-028 Macro ADD_SEQ_OVF_EN defined: OVF_out present, set on RUN->DONE edge to (A[WIDTH-1]==B[WIDTH-1]) && (S[WIDTH-1]!=A[WIDTH-1]), held with S_out.
REQ-029 ADD_SEQ_OVF_EN undefined: OVF_out port and its logic absent; all other behaviour identical.

Verification
REQ-030 A=0x1234, B=0x4321, C_in=0 -> S_out=0x5555, C_out=0, VALID_out exactly 4 cycles after accept.
REQ-031 A=0xFFFF, B=0x0001, C_in=0 -> S_out=0x0000, C_out=1 (carry crosses all 4 slices).
REQ-032 A=0x0000, B=0xFFFF, C_in=1 -> S_out=0x0000, C_out=1; A=0x0F0F, B=0x00F1, C_in=0 -> S_out=0x1000, C_out=0.
REQ-033 READY_in=0 for 6 cycles in DONE with VALID_in pulsing -> S_out/C_out/VALID_out stable, READY_out=0, no new capture; READY_in=1 -> IDLE next cycle.
REQ-034 RSTn_in low during RUN k=2 -> all outputs reset asynchronously, READY_out=1; after release, 0x0001+0x0001 -> S_out=0x0002.
REQ-035 With ADD_SEQ_OVF_EN: 0x7FFF+0x0001 -> S_out=0x8000, OVF_out=1, C_out=0; 0xFFFF+0x0001 -> OVF_out=0, C_out=1.
